// File: rtl/fg_prog_pkg.sv
// ============================================================================
// Package  : fg_prog_pkg
// Brief    : Shared types and island geometry for the floating-gate
//            programming sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fg_prog_pkg;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_INJ  = 2'd1,
        OP_READ = 2'd2,
        OP_RUN  = 2'd3
    } op_e;

    // Response status codes as presented on rsp_status
    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_ERR_RANGE = 2'd1,
        ST_ERR_ARG   = 2'd2,
        ST_ABORTED   = 2'd3
    } status_e;

    // Sequencer control states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Physical array size of each island (rows = vertical decode,
    // columns = horizontal decode)
    localparam int unsigned NUM_ISLANDS = 2;
    localparam int unsigned ROW_LIMIT [NUM_ISLANDS] = '{5, 12};
    localparam int unsigned COL_LIMIT [NUM_ISLANDS] = '{26, 19};

    // True when the island exists and row/col address a real device in it
    function automatic logic in_range(input int unsigned island,
                                      input int unsigned row,
                                      input int unsigned col);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < NUM_ISLANDS; i++) begin
            if (island == i) begin
                ok = (row < ROW_LIMIT[i]) && (col < COL_LIMIT[i]);
            end
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fg_prog_timer.sv
// ============================================================================
// Module   : fg_prog_timer
// Brief    : Loadable down-counter that stops at zero; shared by the
//            setup, pulse and hold phases of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fg_prog_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down and park at zero (no wrap)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fg_prog_sequencer.sv
// ============================================================================
// Module   : fg_prog_sequencer
// Brief    : Single-command floating-gate programming sequencer driving the
//            island decoders, drain select, draincutoff switches and the
//            injection pulse, returning a status response per command.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int ISLAND_BITS  = 1,
    parameter int ROW_BITS     = 6,
    parameter int COL_BITS     = 6,
    parameter int PULSE_W      = 16,
    parameter int SETUP_CYCLES = 8,
    parameter int HOLD_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [ISLAND_BITS-1:0] cmd_island,
    input  logic [ROW_BITS-1:0]    cmd_row,
    input  logic [COL_BITS-1:0]    cmd_col,
    input  logic [PULSE_W-1:0]     cmd_pulse,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    input  logic                   abort,
    output logic [ISLAND_BITS-1:0] island_sel,
    output logic [ROW_BITS-1:0]    vdec_addr,
    output logic [COL_BITS-1:0]    hdec_addr,
    output logic                   dec_en,
    output logic                   drain_sel_en,
    output logic                   prog_sw_en,
    output logic                   run_mode,
    output logic                   vinj_pulse,
    output logic                   busy
);

    // The one counter must hold the largest of the three phase lengths
    localparam int c_setup_w = $clog2(SETUP_CYCLES + 1);
    localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
    localparam int c_sh_w    = (c_setup_w > c_hold_w) ? c_setup_w : c_hold_w;
    localparam int c_cnt_w   = (PULSE_W > c_sh_w) ? PULSE_W : c_sh_w;

    // Phases last N cycles, so the counter is loaded with N-1
    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_setup_load = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load  = c_cnt_w'(HOLD_CYCLES - 1);

    state_e               r_state;
    state_e               w_next;
    op_e                  r_op;
    status_e              r_status;
    logic [PULSE_W-1:0]   r_pulse;

    logic                 w_accept;
    op_e                  w_op;
    logic                 w_is_prog;
    logic                 w_range_ok;
    logic                 w_arg_ok;
    logic                 w_start;
    logic                 w_load;
    logic [c_cnt_w-1:0]   w_load_val;
    logic                 w_zero;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_op       = op_e'(cmd_op);
    assign w_is_prog  = (w_op == OP_INJ) || (w_op == OP_READ);
    assign w_range_ok = in_range(32'(cmd_island), 32'(cmd_row), 32'(cmd_col));
    assign w_arg_ok   = !w_is_prog || (cmd_pulse != '0);
    // A command that actually sequences outputs (not NOP, not rejected)
    assign w_start    = w_range_ok && w_arg_ok && (w_op != OP_NOP);

    fg_prog_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and phase-timer loading
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_start) begin
                        w_next     = S_SETUP;
                        w_load     = 1'b1;
                        w_load_val = c_setup_load;
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_next     = S_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_hold_load;
                end else if (w_zero) begin
                    if (r_op == OP_RUN) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_PULSE;
                        w_load     = 1'b1;
                        w_load_val = c_cnt_w'(r_pulse) - c_one;
                    end
                end
            end
            S_PULSE: begin
                if (abort || w_zero) begin
                    w_next     = S_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_hold_load;
                end
            end
            S_HOLD: begin
                if (w_zero) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command capture and response status; abort during an active phase
    // overrides the eventual status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_NOP;
            r_status <= ST_OK;
            r_pulse  <= '0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_pulse <= cmd_pulse;
            if (!w_range_ok) begin
                r_status <= ST_ERR_RANGE;
            end else if (!w_arg_ok) begin
                r_status <= ST_ERR_ARG;
            end else begin
                r_status <= ST_OK;
            end
        end else if (abort && ((r_state == S_SETUP) || (r_state == S_PULSE) ||
                               (r_state == S_HOLD))) begin
            r_status <= ST_ABORTED;
        end
    end

    // Sticky island controls: addresses hold until the next program command,
    // program/run mode holds until explicitly changed
    always_ff @(posedge clk) begin
        if (rst) begin
            island_sel <= '0;
            vdec_addr  <= '0;
            hdec_addr  <= '0;
            run_mode   <= 1'b1;
            prog_sw_en <= 1'b0;
        end else if (w_accept && w_start) begin
            if (w_is_prog) begin
                island_sel <= cmd_island;
                vdec_addr  <= cmd_row;
                hdec_addr  <= cmd_col;
                run_mode   <= 1'b0;
                prog_sw_en <= 1'b1;
            end else begin
                run_mode   <= 1'b1;
                prog_sw_en <= 1'b0;
            end
        end
    end

    // Phase-derived outputs come straight from the registered state
    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_status   = r_status;
    assign dec_en       = ((r_state == S_SETUP) || (r_state == S_PULSE) ||
                           (r_state == S_HOLD)) && (r_op != OP_RUN);
    assign drain_sel_en = (r_state == S_PULSE);
    assign vinj_pulse   = (r_state == S_PULSE) && (r_op == OP_INJ);

endmodule

`default_nettype wire
